// File: rtl/filter_pkg.sv
// Shared constants, pointer type, control payload and one-hot helper for the
// 5x5 filter align control path.
package filter_pkg;

    localparam int unsigned KERNEL_SIZE    = 5;
    localparam int unsigned LN_BUF_NUM     = 4;
    localparam int unsigned H_ACTIVE_DEF   = 1920;
    localparam int unsigned ADDR_WIDTH_DEF = 12;
    localparam int unsigned ROW_WIDTH_DEF  = 11;
    localparam int unsigned PTR_WIDTH      = 2;
    localparam int unsigned SEL_WIDTH      = 3;

    typedef logic [PTR_WIDTH-1:0] ptr_t;

    // Control word handed to the align stage alongside each pixel
    typedef struct packed {
        logic [LN_BUF_NUM-1:0] mem_wen;
        logic                  mem_ren;
        logic [LN_BUF_NUM-1:0] conv_wen;
        logic                  conv_ren;
        logic [SEL_WIDTH-1:0]  ln_sel;
        logic [SEL_WIDTH-1:0]  px_sel;
        logic                  win_valid;
    } ctrl_t;

    function automatic logic [LN_BUF_NUM-1:0] onehot4(input ptr_t p);
        return LN_BUF_NUM'(1) << p;
    endfunction

endpackage

// File: rtl/filter_rot_cnt.sv
// Mod-4 rotation pointer: exposes the effective (sof-cleared) value and
// advances by i_inc, or loads zero, on each enabled cycle.
module filter_rot_cnt
    import filter_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    input  logic i_en,
    input  logic i_clr,
    input  logic i_zero,
    input  logic i_inc,
    output ptr_t o_ptr_eff_c
);

    ptr_t ptr_q;
    ptr_t ptr_d;
    ptr_t eff_c;

    always_comb begin
        eff_c = i_clr ? '0 : ptr_q;
        ptr_d = ptr_q;
        if (i_en) begin
            ptr_d = i_zero ? '0 : ptr_t'(eff_c + ptr_t'(i_inc));
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign o_ptr_eff_c = eff_c;

endmodule

// File: rtl/filter_align_ctrl_5x5.sv
// Raster-to-window control generator feeding the 5x5 Y-window align stage:
// line-buffer/column-register controls, rotation selects and length checks.
module filter_align_ctrl_5x5
    import filter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned ROW_WIDTH  = ROW_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_valid,
    input  logic                  i_sof,
    input  logic                  i_eol,
    input  logic [DATA_WIDTH-1:0] i_y,
    input  logic [DATA_WIDTH-1:0] i_u,
    input  logic [DATA_WIDTH-1:0] i_v,
    input  logic                  i_err_clr,
    output logic [DATA_WIDTH-1:0] o_y,
    output logic [DATA_WIDTH-1:0] o_u,
    output logic [DATA_WIDTH-1:0] o_v,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [3:0]            o_mem_wen,
    output logic                  o_mem_ren,
    output logic [3:0]            o_conv_wen,
    output logic                  o_conv_ren,
    output logic [2:0]            o_conv_ln_sel,
    output logic [2:0]            o_conv_px_sel,
    output logic                  o_win_valid,
    output logic [ADDR_WIDTH-1:0] o_col,
    output logic [ROW_WIDTH-1:0]  o_row,
    output logic                  o_err_len
);

    localparam int unsigned H_LAST  = H_ACTIVE - 1;
    localparam int unsigned WIN_MIN = KERNEL_SIZE - 1;

    logic [ADDR_WIDTH-1:0] col_q, col_d, col_eff_c;
    logic [ROW_WIDTH-1:0]  row_q, row_d, row_eff_c;
    logic                  err_q, err_d;
    logic                  eol_c, wrap_c, err_set_c;
    ptr_t                  ln_eff_c, px_eff_c;

    logic [DATA_WIDTH-1:0] y_q, y_d, u_q, u_d, v_q, v_d;
    logic [ADDR_WIDTH-1:0] out_col_q, out_col_d;
    logic [ROW_WIDTH-1:0]  out_row_q, out_row_d;
    ctrl_t                 ctrl_q, ctrl_d;

    filter_rot_cnt u_ln_ptr (
        .clk         (clk),
        .rstn        (rstn),
        .i_en        (i_valid),
        .i_clr       (i_sof),
        .i_zero      (1'b0),
        .i_inc       (eol_c),
        .o_ptr_eff_c (ln_eff_c)
    );

    filter_rot_cnt u_px_ptr (
        .clk         (clk),
        .rstn        (rstn),
        .i_en        (i_valid),
        .i_clr       (i_sof),
        .i_zero      (eol_c),
        .i_inc       (1'b1),
        .o_ptr_eff_c (px_eff_c)
    );

    // Effective position, line termination and length-error detection
    always_comb begin
        col_eff_c = i_sof ? '0 : col_q;
        row_eff_c = i_sof ? '0 : row_q;
        wrap_c    = (col_eff_c == ADDR_WIDTH'(H_LAST));
        eol_c     = i_eol | wrap_c;
        err_set_c = i_valid & ((i_eol & !wrap_c)
                             | (wrap_c & !i_eol)
                             | (i_sof & (col_q != '0)));
    end

    // Raster counters and sticky error
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (i_valid) begin
            if (eol_c) begin
                col_d = '0;
                row_d = (&row_eff_c) ? row_eff_c : ROW_WIDTH'(row_eff_c + ROW_WIDTH'(1));
            end else begin
                col_d = ADDR_WIDTH'(col_eff_c + ADDR_WIDTH'(1));
                row_d = row_eff_c;
            end
        end
        if (err_set_c) begin
            err_d = 1'b1;
        end else if (i_err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // Output stage: enables pulse per valid pixel, data and selects hold otherwise
    always_comb begin
        y_d       = y_q;
        u_d       = u_q;
        v_d       = v_q;
        out_col_d = out_col_q;
        out_row_d = out_row_q;
        ctrl_d           = ctrl_q;
        ctrl_d.mem_wen   = '0;
        ctrl_d.mem_ren   = 1'b0;
        ctrl_d.conv_wen  = '0;
        ctrl_d.conv_ren  = 1'b0;
        ctrl_d.win_valid = 1'b0;
        if (i_valid) begin
            y_d       = i_y;
            u_d       = i_u;
            v_d       = i_v;
            out_col_d = col_eff_c;
            out_row_d = row_eff_c;
            ctrl_d.mem_wen   = onehot4(ln_eff_c);
            ctrl_d.mem_ren   = 1'b1;
            ctrl_d.conv_wen  = onehot4(px_eff_c);
            ctrl_d.conv_ren  = 1'b1;
            ctrl_d.ln_sel    = SEL_WIDTH'(ln_eff_c);
            ctrl_d.px_sel    = SEL_WIDTH'(px_eff_c);
            ctrl_d.win_valid = (row_eff_c >= ROW_WIDTH'(WIN_MIN))
                             & (col_eff_c >= ADDR_WIDTH'(WIN_MIN));
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col_q     <= '0;
            row_q     <= '0;
            err_q     <= 1'b0;
            y_q       <= '0;
            u_q       <= '0;
            v_q       <= '0;
            out_col_q <= '0;
            out_row_q <= '0;
            ctrl_q    <= '0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            err_q     <= err_d;
            y_q       <= y_d;
            u_q       <= u_d;
            v_q       <= v_d;
            out_col_q <= out_col_d;
            out_row_q <= out_row_d;
            ctrl_q    <= ctrl_d;
        end
    end

    assign o_y           = y_q;
    assign o_u           = u_q;
    assign o_v           = v_q;
    assign o_mem_addr    = out_col_q;
    assign o_col         = out_col_q;
    assign o_row         = out_row_q;
    assign o_mem_wen     = ctrl_q.mem_wen;
    assign o_mem_ren     = ctrl_q.mem_ren;
    assign o_conv_wen    = ctrl_q.conv_wen;
    assign o_conv_ren    = ctrl_q.conv_ren;
    assign o_conv_ln_sel = ctrl_q.ln_sel;
    assign o_conv_px_sel = ctrl_q.px_sel;
    assign o_win_valid   = ctrl_q.win_valid;
    assign o_err_len     = err_q;

endmodule

// File: doc/filter_align_ctrl_5x5.md
Name: filter_align_ctrl_5x5

Overview:
- Upstream control stage for the 5x5 Y-window data-align block.
- Accepts a raster pixel stream (valid/sof/eol-framed YUV).
- Generates the line-buffer write/read controls, column-register write enables and the line/pixel rotation selects that the align stage consumes, with the pixel data registered alongside them.
- Also flags where a full 5x5 window is valid, and detects malformed line lengths.

Parameters:
- DATA_WIDTH, 8, pixel component width.
- H_ACTIVE, 1920, expected pixels per line; line-buffer depth.
- ADDR_WIDTH, 12, line-buffer address width (must satisfy 2^ADDR_WIDTH >= H_ACTIVE).
- ROW_WIDTH, 11, row counter width.

Ports:
- clk  in  1  clock
- rstn  in  1  reset
- i_valid  in  1  pixel valid
- i_sof  in  1  first pixel of frame; qualified by i_valid
- i_eol  in  1  last pixel of line; qualified by i_valid
- i_y / i_u / i_v  in  DATA_WIDTH each  pixel components
- i_err_clr  in  1  clears o_err_len
- o_y / o_u / o_v  out  DATA_WIDTH each  registered pixel
- o_mem_addr  out  ADDR_WIDTH  line-buffer address (column)
- o_mem_wen  out  4  one-hot line-buffer write enable
- o_mem_ren  out  1  line-buffer read enable
- o_conv_wen  out  4  one-hot column-register write enable
- o_conv_ren  out  1  window read enable
- o_conv_ln_sel  out  3  line rotation select, values 0..3
- o_conv_px_sel  out  3  pixel rotation select, values 0..3
- o_win_valid  out  1  current output pixel completes a full 5x5 window
- o_col  out  ADDR_WIDTH  column of output pixel
- o_row  out  ROW_WIDTH  row of output pixel
- o_err_len  out  1  sticky line-length error

Behaviour:
- Clock and reset: single clock clk; rstn is asynchronous and active-low. Every output and internal register is 0 during reset.
- Latency: all outputs are registered. A pixel accepted at edge t appears on o_y/u/v with all of its controls at t+1.
- Idle cycles (i_valid=0):
  - o_mem_wen, o_conv_wen, o_mem_ren, o_conv_ren and o_win_valid are 0.
  - Data, address and selects hold.
  - i_sof/i_eol are ignored.
- Internal state:
  - col (ADDR_WIDTH), row (ROW_WIDTH).
  - ln_ptr (mod 4), px_ptr (mod 4).
  - err (sticky).
- Per valid pixel, the output stage loads:
  - o_y/u/v = inputs
  - o_mem_addr = o_col = col_eff
  - o_row = row_eff
  - o_mem_wen = onehot(ln_ptr_eff)
  - o_conv_wen = onehot(px_ptr_eff)
  - o_conv_ln_sel = ln_ptr_eff; o_conv_px_sel = px_ptr_eff
  - o_mem_ren = o_conv_ren = 1
  - o_win_valid = (row_eff>=4 && col_eff>=4)
- Effective values: if i_sof, col_eff=row_eff=ln_ptr_eff=px_ptr_eff=0; otherwise they equal the stored counters.
- Counter update after a valid pixel:
  - End of line is i_eol, or col_eff==H_ACTIVE-1 (forced wrap).
  - At end of line: col<=0, px_ptr<=0, ln_ptr<=ln_ptr_eff+1 mod 4, row<=row_eff+1, saturating at all-ones.
  - Otherwise: col<=col_eff+1, px_ptr<=px_ptr_eff+1 mod 4, with row and ln_ptr reloaded from their effective values.
- Error detection:
  - err sets when i_eol arrives with col_eff!=H_ACTIVE-1.
  - err sets on a forced wrap without i_eol.
  - err sets when i_sof arrives while stored col!=0 (mid-line abort).
- Error clear:
  - i_err_clr clears err.
  - If a set condition occurs in the same cycle as i_err_clr, set wins.
  - o_err_len = err, registered.
- Simultaneous i_sof and i_eol: a one-pixel line at row 0. The next row is 1 and ln_ptr becomes 1. err sets unless H_ACTIVE==1.
- Reset mid-line: all state returns to 0 immediately. The next pixel is treated as col 0, row 0 even without i_sof.
- Pointer encoding: ln_ptr and px_ptr never exceed 3. The select outputs never take value 4 or more.

Decomposition:
- Shared package filter_pkg holds:
  - KERNEL_SIZE=5 and LN_BUF_NUM=4.
  - The default H_ACTIVE/ADDR_WIDTH constants.
  - A onehot4 function.
- One natural sub-module, filter_rot_cnt: a mod-4 pointer with load-zero and increment inputs, instantiated for ln_ptr and px_ptr.

Test Plan:
- Reset/idle: hold rstn=0, then release with i_valid=0 for 10 cycles -> all outputs 0, o_conv_ln_sel=o_conv_px_sel=0.
- Nominal frame: H_ACTIVE=8, send 6 lines of 8 pixels (sof on the first, eol on each 8th), Y equal to 8*row+col.
  - Output pixel at t+1.
  - o_mem_wen cycles 0001, 0010, 0100, 1000, 0001, 0010 per line.
  - o_conv_wen cycles 0001..1000 within a line.
  - o_win_valid=1 only for row 4..5, col 4..7, i.e. 8 pulses.
- Bubbles: the same frame with i_valid low every other cycle -> identical output sequence; zero enables on idle cycles.
- Short line: eol at col 5 with H_ACTIVE=8 -> o_err_len=1 from the next cycle, next line starts at col 0 with ln_sel advanced; i_err_clr pulse -> 0.
- Missing eol: 10 pixels without eol -> wrap after col 7, row increments, err set, pixel 9 lands at col 0 of the next row.
- Mid-line sof: sof at col 3 of row 2 -> output col 0, row 0, sel 0, err set. Asserting rstn low at col 5 instead -> all outputs 0 at once.
